reg_file_mp: RTL

Parametrised multi-read-port register file: the next-generation general-purpose register store between decode and the ALU. It adds configurable width, depth and read-port count, write enable, registered reads with optional write-to-read bypass, a hardwired-zero register option, and a handshaked soft-clear sequencer that zeroes the array one entry per cycle without asserting reset.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_rd_port.sv | 57 +++++
 rtl/reg_file_mp.sv | 125 ++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the general-purpose register file: soft-clear
// sequencer states and the default geometry used by decode and the ALU.
package reg_file_pkg;

    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_ADDR_WIDTH = 4;
    localparam int RF_NUM_RD     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
`timescale 1ns/1ps
// One registered read port: selects between the stored entry, a same-cycle
// forwarded write and the hardwired zero of R0, then registers the result.
module reg_file_rd_port #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] entry_val,
    input  logic                  wr_fire,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  is_zero_reg;
    logic                  bypass_hit;

    // R0 masking takes priority so a discarded R0 write is never forwarded.
    always_comb begin
        is_zero_reg = ZERO_REG && (rd_addr == '0);
        bypass_hit  = BYPASS && wr_fire && (wr_addr == rd_addr) && !is_zero_reg;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_en;
        if (rd_en) begin
            if (is_zero_reg) begin
                rd_data_d = '0;
            end else if (bypass_hit) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = entry_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/reg_file_mp.sv
`timescale 1ns/1ps
// Multi-read-port register file with write enable, optional bypass and
// hardwired R0, plus a sequencer that soft-clears one entry per cycle.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_ready,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         clr_done
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_busy_q, clr_busy_d;
    logic                  clr_done_q, clr_done_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_fire;

    assign wr_ready = (state_q == IDLE);
    assign wr_fire  = wr_en && wr_ready;

    // The sweep counter parks at the last address; it is rezeroed on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr_busy_d = (state_d == CLEAR);
        clr_done_d = (state_d == DONE);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_fire && !(ZERO_REG && (wr_addr == '0))) begin
            mem_d[wr_addr] = wr_data;
        end
        if (state_q == CLEAR) begin
            mem_d[cnt_q] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] port_addr;
        assign port_addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        reg_file_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_rd_port (
            .clk       (clk),
            .rst       (rst),
            .rd_en     (rd_en[p]),
            .rd_addr   (port_addr),
            .entry_val (mem_q[port_addr]),
            .wr_fire   (wr_fire),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_data   (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid  (rd_valid[p])
        );
    end

endmodule
